// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU control sequencer: walks each instruction through operand load,
// execute and write-back, driving bus selects, latch enables and the ALU code.
module alu_op_sequencer (
    input  logic       clock,
    input  logic       clear,
    input  logic       start,
    input  logic [4:0] op,
    input  logic [3:0] ra,
    input  logic [3:0] rb,
    input  logic [3:0] rc,
    input  logic       hold,
    output logic       ready,
    output logic       reg_out_en,
    output logic [3:0] reg_out_sel,
    output logic       reg_in_en,
    output logic [3:0] reg_in_sel,
    output logic       y_in,
    output logic       z_in,
    output logic [4:0] alu_control,
    output logic       zlow_out,
    output logic       zhigh_out,
    output logic       lo_in,
    output logic       hi_in,
    output logic       done,
    output logic       illegal
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_Y = 3'd1,
        EXEC   = 3'd2,
        WB_LO  = 3'd3,
        WB_HI  = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] op_q, op_d;
    logic [3:0] ra_q, ra_d;
    logic [3:0] rb_q, rb_d;
    logic [3:0] rc_q, rc_d;

    function automatic logic op_is_unary(input logic [4:0] code);
        return (code == 5'b10001) || (code == 5'b10010);
    endfunction

    function automatic logic op_is_wide(input logic [4:0] code);
        return (code == 5'b01111) || (code == 5'b10000);
    endfunction

    function automatic logic op_is_legal(input logic [4:0] code);
        // Binary ops occupy the contiguous range add..rol.
        return ((code >= 5'b00011) && (code <= 5'b01011)) ||
               op_is_unary(code) || op_is_wide(code);
    endfunction

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rc_d    = rc_q;
        if (!hold) begin
            case (state_q)
                IDLE: begin
                    if (start && op_is_legal(op)) begin
                        state_d = LOAD_Y;
                        op_d    = op;
                        ra_d    = ra;
                        rb_d    = rb;
                        rc_d    = rc;
                    end
                end
                LOAD_Y:  state_d = EXEC;
                EXEC:    state_d = WB_LO;
                WB_LO:   state_d = op_is_wide(op_q) ? WB_HI : IDLE;
                WB_HI:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            op_q    <= 5'd0;
            ra_q    <= 4'd0;
            rb_q    <= 4'd0;
            rc_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rc_q    <= rc_d;
        end
    end

    // alu_control ignores hold so the ALU result stays stable while Z is stalled.
    always_comb begin
        ready       = 1'b0;
        reg_out_en  = 1'b0;
        reg_out_sel = 4'd0;
        reg_in_en   = 1'b0;
        reg_in_sel  = 4'd0;
        y_in        = 1'b0;
        z_in        = 1'b0;
        alu_control = (state_q == EXEC) ? op_q : 5'd0;
        zlow_out    = 1'b0;
        zhigh_out   = 1'b0;
        lo_in       = 1'b0;
        hi_in       = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        if (!hold) begin
            case (state_q)
                IDLE: begin
                    ready   = 1'b1;
                    illegal = start && !op_is_legal(op);
                end
                LOAD_Y: begin
                    reg_out_en  = 1'b1;
                    reg_out_sel = rb_q;
                    y_in        = 1'b1;
                end
                EXEC: begin
                    z_in = 1'b1;
                    if (!op_is_unary(op_q)) begin
                        reg_out_en  = 1'b1;
                        reg_out_sel = rc_q;
                    end
                end
                WB_LO: begin
                    zlow_out = 1'b1;
                    if (op_is_wide(op_q)) begin
                        lo_in = 1'b1;
                    end else begin
                        reg_in_en  = 1'b1;
                        reg_in_sel = ra_q;
                        done       = 1'b1;
                    end
                end
                WB_HI: begin
                    zhigh_out = 1'b1;
                    hi_in     = 1'b1;
                    done      = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: the driver queues the expected output vector
// for every active cycle and a negedge monitor pops and compares.
module tb_alu_op_sequencer;
  localparam int W = 24;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic       start = 1'b0;
  logic [4:0] op = 5'd0;
  logic [3:0] ra = 4'd0;
  logic [3:0] rb = 4'd0;
  logic [3:0] rc = 4'd0;
  logic       hold = 1'b0;
  logic       ready, reg_out_en, reg_in_en, y_in, z_in;
  logic [3:0] reg_out_sel, reg_in_sel;
  logic [4:0] alu_control;
  logic       zlow_out, zhigh_out, lo_in, hi_in, done, illegal;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] act;
  int total = 0;
  int bad = 0;

  alu_op_sequencer dut (
    .clock(clock), .clear(clear), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
    .hold(hold), .ready(ready), .reg_out_en(reg_out_en), .reg_out_sel(reg_out_sel),
    .reg_in_en(reg_in_en), .reg_in_sel(reg_in_sel), .y_in(y_in), .z_in(z_in),
    .alu_control(alu_control), .zlow_out(zlow_out), .zhigh_out(zhigh_out),
    .lo_in(lo_in), .hi_in(hi_in), .done(done), .illegal(illegal)
  );

  always #5 clock = ~clock;

  // Vector layout: {roe, ros, rie, ris, y, z, alu, zl, zh, lo, hi, done, illegal, ready}
  function automatic logic [W-1:0] ev(input logic roe, input logic [3:0] ros,
                                      input logic rie, input logic [3:0] ris,
                                      input logic y, input logic z, input logic [4:0] alu,
                                      input logic zl, input logic zh, input logic lo,
                                      input logic hi, input logic dn, input logic il,
                                      input logic rdy);
    return {roe, ros, rie, ris, y, z, alu, zl, zh, lo, hi, dn, il, rdy};
  endfunction

  localparam logic [W-1:0] RST_V = 24'h000001;

  always_comb act = ev(reg_out_en, reg_out_sel, reg_in_en, reg_in_sel, y_in, z_in,
                       alu_control, zlow_out, zhigh_out, lo_in, hi_in, done, illegal, ready);

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: any cycle with a strobe, select, ALU code or illegal set is an event.
  always @(negedge clock) begin
    if (|act[W-1:1]) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got=%h want=none at %0t", act, $time);
      end else begin
        check("event", act, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issues one instruction in the current (ready) cycle; optionally stalls for
  // hold_len cycles at the start of phase hold_ph (0=LOAD_Y, 1=EXEC, ...).
  task automatic run_op(input logic [4:0] o, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input int hold_ph, input int hold_len);
    logic [W-1:0] ph[4];
    logic [W-1:0] held;
    logic un, wd;
    int n;
    un = (o == 5'b10001) || (o == 5'b10010);
    wd = (o == 5'b01111) || (o == 5'b10000);
    n  = wd ? 4 : 3;
    ph[0] = ev(1'b1, b, 1'b0, 4'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ph[1] = ev(!un, un ? 4'd0 : c, 1'b0, 4'd0, 1'b0, 1'b1, o, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (wd) begin
      ph[2] = ev(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      ph[3] = ev(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    end else begin
      ph[2] = ev(1'b0, 4'd0, 1'b1, a, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      ph[3] = '0;
    end
    start = 1'b1; op = o; ra = a; rb = b; rc = c;
    tick();
    // Not ready: this second start must be ignored, and later input changes must not leak in.
    op = 5'b00110; ra = ~a; rb = ~b; rc = ~c;
    for (int p = 0; p < n; p++) begin
      if (p == 1) start = 1'b0;
      if (p == hold_ph) begin
        for (int h = 0; h < hold_len; h++) begin
          hold = 1'b1;
          held = ev(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, (p == 1) ? o : 5'd0,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
          if (|held) exp_q.push_back(held);
          tick();
        end
      end
      hold = 1'b0;
      exp_q.push_back(ph[p]);
      tick();
    end
    start = 1'b0;
    check("ready_after_op", {23'd0, ready}, 24'd1);
  endtask

  task automatic try_illegal(input logic [4:0] o);
    exp_q.push_back(ev(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 5'd0,
                       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    start = 1'b1; op = o; ra = 4'd1; rb = 4'd2; rc = 4'd3;
    tick();
    start = 1'b0;
    tick();
    check("ready_after_illegal", {23'd0, ready}, 24'd1);
  endtask

  initial begin
    #3;
    check("reset_outputs", act, RST_V);
    tick();
    clear = 1'b0;
    tick();
    check("idle_after_reset", act, RST_V);

    run_op(5'b00011, 4'd3, 4'd1, 4'd2, -1, 0);   // add
    run_op(5'b10010, 4'd5, 4'd4, 4'd0, -1, 0);   // not, back-to-back
    run_op(5'b01111, 4'd6, 4'd7, 4'd8, -1, 0);   // mul
    try_illegal(5'b01100);
    try_illegal(5'b00000);
    try_illegal(5'b11111);
    run_op(5'b00011, 4'd3, 4'd1, 4'd2, 1, 2);    // add stalled in EXEC
    run_op(5'b00100, 4'd9, 4'd9, 4'd9, -1, 0);   // sub, ra=rb=rc
    run_op(5'b00101, 4'd0, 4'd15, 4'd14, 0, 1);  // and, stall in LOAD_Y
    run_op(5'b01011, 4'd15, 4'd0, 4'd1, -1, 0);  // rol
    run_op(5'b10001, 4'd2, 4'd11, 4'd12, 2, 1);  // neg, stall in WB_LO
    run_op(5'b10000, 4'd4, 4'd5, 4'd6, 3, 1);    // div, stall in WB_HI

    // Start under hold in IDLE is not accepted.
    hold = 1'b1; start = 1'b1; op = 5'b00011;
    #1;
    check("hold_idle_ready", act, '0);
    tick();
    hold = 1'b0; start = 1'b0;
    tick();
    check("idle_after_hold", act, RST_V);

    // Clear during WB_HI of a div: no done may follow.
    exp_q.push_back(ev(1'b1, 4'd8, 1'b0, 4'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(1'b1, 4'd10, 1'b0, 4'd0, 1'b0, 1'b1, 5'b10000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    start = 1'b1; op = 5'b10000; ra = 4'd7; rb = 4'd8; rc = 4'd10;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    clear = 1'b1;
    #1;
    check("clear_mid_op", act, RST_V);
    tick();
    clear = 1'b0;
    tick();
    check("ready_after_clear", act, RST_V);
    tick(); tick(); tick();

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_events: got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
